// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with pixel strobe and output delay line
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int DELAY     = 0,
    parameter int FCW       = 8,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW       = $clog2(H_TOTAL),
    localparam int YW       = $clog2(V_TOTAL)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           en_i,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           visible_o,
    output logic [XW-1:0]  position_x_o,
    output logic [YW-1:0]  position_y_o,
    output logic           line_start_o,
    output logic           frame_start_o,
    output logic           pix_valid_o,
    output logic [FCW-1:0] frame_count_o
);

    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_VIS_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_VIS_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);

    // Bundle layout: {hsync, vsync, visible, line_start, frame_start, x, y}
    localparam int BW     = XW + YW + 5;
    localparam int FS_BIT = XW + YW;
    localparam logic [BW-1:0] RST_BUNDLE = {~HSYNC_POL, ~VSYNC_POL, 3'b000, {XW{1'b0}}, {YW{1'b0}}};

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        DELAY < 0 || DELAY > 15 || FCW < 1) begin : g_param_check
        $error("vga_timing_gen: timing parameters must be >= 1 and DELAY in 0..15");
    end

    logic [XW-1:0] h;
    logic [YW-1:0] v;
    logic [BW-1:0] dec;
    logic [BW-1:0] pipe [0:DELAY];
    logic [BW-1:0] last_in;
    logic [FCW-1:0] frame_count;
    logic           pix_valid;

    // Raster counters: one pixel per strobe, line wrap carries into the row counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h <= '0;
            v <= '0;
        end else if (en_i) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + YW'(1);
            end else begin
                h <= h + XW'(1);
            end
        end
    end

    // Decode the current counter position into the output bundle
    always_comb begin
        dec = RST_BUNDLE;
        dec[BW-1] = ((h >= H_SYNC_BEG) && (h < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
        dec[BW-2] = ((v >= V_SYNC_BEG) && (v < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
        dec[BW-3] = (h < H_VIS_END) && (v < V_VIS_END);
        dec[BW-4] = (h == '0);
        dec[BW-5] = (h == '0) && (v == '0);
        dec[FS_BIT-1:0] = {h, v};
    end

    // Delay line: stage 0 takes the fresh decode, later stages shift on each pixel strobe
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i <= DELAY; i++) pipe[i] <= RST_BUNDLE;
        end else if (en_i) begin
            pipe[0] <= dec;
            for (int i = 1; i <= DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // The bundle about to enter the output stage decides whether a frame starts at the pins
    if (DELAY == 0) begin : g_last_dec
        assign last_in = dec;
    end else begin : g_last_pipe
        assign last_in = pipe[DELAY-1];
    end

    // Frame counter stays aligned with frame_start at the output pins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_count <= '0;
        end else if (en_i && last_in[FS_BIT]) begin
            frame_count <= frame_count + FCW'(1);
        end
    end

    // Output-updated flag is the strobe delayed by one clock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= en_i;
        end
    end

    assign {hsync_o, vsync_o, visible_o, line_start_o, frame_start_o,
            position_x_o, position_y_o} = pipe[DELAY];
    assign frame_count_o = frame_count;
    assign pix_valid_o   = pix_valid;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard and table-driven bench for vga_timing_gen
module tb_vga_timing_gen;

    typedef struct packed {
        int hs; int vs; int vis; int x; int y; int ls; int fs;
    } pix_t;

    typedef struct packed {
        logic en;
        int x; int y; int hs; int vs; int vis; int ls; int fs; int pv; int fc;
    } vec_t;

    logic clk;
    logic rst_n;
    logic en;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: default geometry
    logic a_hs, a_vs, a_vis, a_ls, a_fs, a_pv;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    // Instance b: default geometry, DELAY=3
    logic b_hs, b_vs, b_vis, b_ls, b_fs, b_pv;
    logic [9:0] b_x, b_y;
    logic [7:0] b_fc;
    // Instance c: small geometry, positive sync
    logic c_hs, c_vs, c_vis, c_ls, c_fs, c_pv;
    logic [2:0] c_x, c_y;
    logic [7:0] c_fc;
    // Instance d: small geometry, FCW=2
    logic d_hs, d_vs, d_vis, d_ls, d_fs, d_pv;
    logic [2:0] d_x, d_y;
    logic [1:0] d_fc;

    vga_timing_gen u_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .hsync_o(a_hs), .vsync_o(a_vs), .visible_o(a_vis),
        .position_x_o(a_x), .position_y_o(a_y),
        .line_start_o(a_ls), .frame_start_o(a_fs),
        .pix_valid_o(a_pv), .frame_count_o(a_fc)
    );

    vga_timing_gen #(.DELAY(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .hsync_o(b_hs), .vsync_o(b_vs), .visible_o(b_vis),
        .position_x_o(b_x), .position_y_o(b_y),
        .line_start_o(b_ls), .frame_start_o(b_fs),
        .pix_valid_o(b_pv), .frame_count_o(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u_c (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .hsync_o(c_hs), .vsync_o(c_vs), .visible_o(c_vis),
        .position_x_o(c_x), .position_y_o(c_y),
        .line_start_o(c_ls), .frame_start_o(c_fs),
        .pix_valid_o(c_pv), .frame_count_o(c_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .FCW(2)
    ) u_d (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .hsync_o(d_hs), .vsync_o(d_vs), .visible_o(d_vis),
        .position_x_o(d_x), .position_y_o(d_y),
        .line_start_o(d_ls), .frame_start_o(d_fs),
        .pix_valid_o(d_pv), .frame_count_o(d_fc)
    );

    int   sel;
    pix_t obs;
    int   obs_fc;
    logic obs_pv;

    always_comb begin
        obs    = '0;
        obs_fc = 0;
        obs_pv = 1'b0;
        case (sel)
            0: begin
                obs = '{int'(a_hs), int'(a_vs), int'(a_vis), int'(a_x), int'(a_y), int'(a_ls), int'(a_fs)};
                obs_fc = int'(a_fc); obs_pv = a_pv;
            end
            1: begin
                obs = '{int'(b_hs), int'(b_vs), int'(b_vis), int'(b_x), int'(b_y), int'(b_ls), int'(b_fs)};
                obs_fc = int'(b_fc); obs_pv = b_pv;
            end
            2: begin
                obs = '{int'(c_hs), int'(c_vs), int'(c_vis), int'(c_x), int'(c_y), int'(c_ls), int'(c_fs)};
                obs_fc = int'(c_fc); obs_pv = c_pv;
            end
            default: begin
                obs = '{int'(d_hs), int'(d_vs), int'(d_vis), int'(d_x), int'(d_y), int'(d_ls), int'(d_fs)};
                obs_fc = int'(d_fc); obs_pv = d_pv;
            end
        endcase
    end

    int errors = 0;
    int checks = 0;

    int c_ha, c_hf, c_hsw, c_hb, c_va, c_vf, c_vsw, c_vb, c_hp, c_vp, c_dl, c_fm;
    int mh, mv, mfc;
    pix_t q[$];
    pix_t last;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pix(input string name, input pix_t act, input pix_t exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d hs=%0d vs=%0d vis=%0d ls=%0d fs=%0d expected x=%0d y=%0d hs=%0d vs=%0d vis=%0d ls=%0d fs=%0d",
                     name, act.x, act.y, act.hs, act.vs, act.vis, act.ls, act.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.vis, exp.ls, exp.fs);
        end
    endtask

    function automatic pix_t model_decode(input int h, input int v);
        pix_t p;
        p.hs  = (h >= c_ha + c_hf && h < c_ha + c_hf + c_hsw) ? c_hp : 1 - c_hp;
        p.vs  = (v >= c_va + c_vf && v < c_va + c_vf + c_vsw) ? c_vp : 1 - c_vp;
        p.vis = (h < c_ha && v < c_va) ? 1 : 0;
        p.x   = h;
        p.y   = v;
        p.ls  = (h == 0) ? 1 : 0;
        p.fs  = (h == 0 && v == 0) ? 1 : 0;
        return p;
    endfunction

    function automatic pix_t reset_pix();
        pix_t p;
        p = '0;
        p.hs = 1 - c_hp;
        p.vs = 1 - c_vp;
        return p;
    endfunction

    task automatic set_cfg(input int id);
        sel = id;
        if (id < 2) begin
            c_ha = 640; c_hf = 16; c_hsw = 96; c_hb = 48;
            c_va = 480; c_vf = 10; c_vsw = 2;  c_vb = 33;
            c_hp = 0;   c_vp = 0;
        end else begin
            c_ha = 4; c_hf = 1; c_hsw = 2; c_hb = 1;
            c_va = 3; c_vf = 1; c_vsw = 1; c_vb = 1;
            c_hp = 1; c_vp = 1;
        end
        c_dl = (id == 1) ? 3 : 0;
        c_fm = (id == 3) ? 4 : 256;
    endtask

    task automatic model_reset();
        mh = 0;
        mv = 0;
        mfc = 0;
        last = reset_pix();
        q.delete();
        for (int i = 0; i < c_dl; i++) q.push_back(reset_pix());
    endtask

    // Asserts reset mid-phase, checks the asynchronous effect and the hold, then releases
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_pix("async_reset", obs, last);
        check_int("async_reset_fc", obs_fc, 0);
        check_int("async_reset_pv", int'(obs_pv), 0);
        repeat (2) @(negedge clk);
        check_pix("held_in_reset", obs, last);
        rst_n = 1'b1;
    endtask

    // One clock with the given strobe; the scoreboard pushes the model pixel and pops the output one
    task automatic step(input logic e);
        pix_t exp;
        int htot, vtot;
        htot = c_ha + c_hf + c_hsw + c_hb;
        vtot = c_va + c_vf + c_vsw + c_vb;
        en = e;
        @(posedge clk);
        #1;
        if (e) begin
            q.push_back(model_decode(mh, mv));
            mh++;
            if (mh == htot) begin
                mh = 0;
                mv++;
                if (mv == vtot) mv = 0;
            end
            exp = q.pop_front();
            if (exp.fs == 1) mfc = (mfc + 1) % c_fm;
            last = exp;
            check_int("pix_valid", int'(obs_pv), 1);
        end else begin
            check_int("pix_valid_idle", int'(obs_pv), 0);
        end
        check_pix("pixel", obs, last);
        check_int("frame_count", obs_fc, mfc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[11];
        int   fc_seq[5];
        int   t_prev, t_fs, hs_lo, hs_first_x, first_fs, fs_x, fs_y, fs_vis, nfs, reached;
        pix_t tp, cp;

        tbl[0]  = '{1'b1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        tbl[1]  = '{1'b0, 0, 0, 0, 0, 1, 1, 1, 0, 1};
        tbl[2]  = '{1'b1, 1, 0, 0, 0, 1, 0, 0, 1, 1};
        tbl[3]  = '{1'b1, 2, 0, 0, 0, 1, 0, 0, 1, 1};
        tbl[4]  = '{1'b1, 3, 0, 0, 0, 1, 0, 0, 1, 1};
        tbl[5]  = '{1'b1, 4, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{1'b1, 5, 0, 1, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{1'b0, 5, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{1'b1, 6, 0, 1, 0, 0, 0, 0, 1, 1};
        tbl[9]  = '{1'b1, 7, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[10] = '{1'b1, 0, 1, 0, 0, 1, 1, 0, 1, 1};
        fc_seq = '{1, 2, 3, 0, 1};

        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 0;
        set_cfg(0);
        repeat (2) @(negedge clk);

        // Default geometry, continuous strobe
        set_cfg(0);
        do_reset();
        t_prev = -1; hs_lo = 0; hs_first_x = -1;
        for (int i = 0; i < 1700; i++) begin
            step(1'b1);
            if (obs.ls == 1) begin
                if (t_prev >= 0) check_int("line_period", i - t_prev, 800);
                t_prev = i;
            end
            if (i < 800 && obs.hs == 0) begin
                hs_lo++;
                if (hs_first_x < 0) hs_first_x = obs.x;
            end
        end
        check_int("hsync_width", hs_lo, 96);
        check_int("hsync_start_x", hs_first_x, 656);

        // Default geometry, strobe every other clock
        set_cfg(0);
        do_reset();
        t_prev = -1;
        for (int i = 0; i < 3400; i++) begin
            step((i % 2) == 0);
            if (obs_pv && obs.ls == 1) begin
                if (t_prev >= 0) check_int("line_period_half_rate", i - t_prev, 1600);
                t_prev = i;
            end
        end

        // DELAY=3 latency
        set_cfg(1);
        do_reset();
        first_fs = -1; fs_x = -1; fs_y = -1; fs_vis = -1;
        for (int i = 1; i <= 900; i++) begin
            step(1'b1);
            if (obs.fs == 1 && first_fs < 0) begin
                first_fs = i; fs_x = obs.x; fs_y = obs.y; fs_vis = obs.vis;
            end
        end
        check_int("d3_first_frame_start", first_fs, 4);
        check_int("d3_fs_x", fs_x, 0);
        check_int("d3_fs_y", fs_y, 0);
        check_int("d3_fs_visible", fs_vis, 1);

        // Small geometry: hand-derived vectors, then free run
        set_cfg(2);
        do_reset();
        for (int k = 0; k < 11; k++) begin
            step(tbl[k].en);
            tp = '{tbl[k].hs, tbl[k].vs, tbl[k].vis, tbl[k].x, tbl[k].y, tbl[k].ls, tbl[k].fs};
            cp = '{int'(c_hs), int'(c_vs), int'(c_vis), int'(c_x), int'(c_y), int'(c_ls), int'(c_fs)};
            check_pix("vec_pixel", cp, tp);
            check_int("vec_pix_valid", int'(c_pv), tbl[k].pv);
            check_int("vec_frame_count", int'(c_fc), tbl[k].fc);
        end
        nfs = 1; t_prev = -1; t_fs = -1;
        for (int i = 0; i < 140; i++) begin
            step(1'b1);
            if (obs.hs == 1) check_int("sm_hsync_at_x5_6", (obs.x == 5 || obs.x == 6) ? 1 : 0, 1);
            if (obs.vs == 1) check_int("sm_vsync_at_y4", obs.y, 4);
            if (obs.ls == 1) begin
                if (t_prev >= 0) check_int("sm_line_period", i - t_prev, 8);
                t_prev = i;
            end
            if (obs.fs == 1) begin
                nfs++;
                check_int("sm_frame_count_at_start", obs_fc, nfs);
                if (t_fs >= 0) check_int("sm_frame_period", i - t_fs, 48);
                t_fs = i;
            end
        end
        check_int("sm_frames_seen", nfs, 4);

        // Reset in the middle of a frame with the strobe high
        set_cfg(0);
        do_reset();
        reached = 0;
        for (int i = 0; i < 5000 && reached == 0; i++) begin
            step(1'b1);
            if (obs.x == 100 && obs.y == 2) reached = 1;
        end
        check_int("reach_mid_frame", reached, 1);
        do_reset();
        step(1'b1);
        check_int("restart_x", obs.x, 0);
        check_int("restart_y", obs.y, 0);
        check_int("restart_frame_start", obs.fs, 1);
        for (int i = 0; i < 900; i++) step(1'b1);

        // FCW=2 wrap over five frames
        set_cfg(3);
        do_reset();
        nfs = 0;
        for (int i = 0; i < 240; i++) begin
            step(1'b1);
            if (obs_pv && obs.fs == 1) begin
                if (nfs < 5) check_int("f2_frame_count", obs_fc, fc_seq[nfs]);
                nfs++;
            end
        end
        check_int("f2_frames_seen", nfs, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
